// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the frame-buffer RAM port arbiter.
// Holds the FSM encoding, default bus widths and the pointer wrap helper.
package frame_buf_pkg;

   localparam int unsigned DEF_ADDR_W = 29;
   localparam int unsigned DEF_DATA_W = 32;

   localparam logic ASSERT_H   = 1'b1;
   localparam logic DEASSERT_H = 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_e;

   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/frame_buf_arb_if.sv
// Avalon command/read-return bus between the arbiter (master) and the RAM
// interface port (slave).
interface frame_buf_arb_if
   import frame_buf_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              avl_ready;
   logic              avl_write_req;
   logic              avl_read_req;
   logic [ADDR_W-1:0] avl_addr;
   logic [DATA_W-1:0] avl_wdata;
   logic              avl_rd_data_valid;
   logic [DATA_W-1:0] avl_rd_data;

   modport master (
      input  avl_ready,
      output avl_write_req,
      output avl_read_req,
      output avl_addr,
      output avl_wdata,
      input  avl_rd_data_valid,
      input  avl_rd_data
   );

   modport slave (
      output avl_ready,
      input  avl_write_req,
      input  avl_read_req,
      input  avl_addr,
      input  avl_wdata,
      output avl_rd_data_valid,
      output avl_rd_data
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or above
// the pointer, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);
   int unsigned      c_full;
   logic [IDX_W-1:0] c;

   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      c_full = 0;
      c      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         c_full = (32'(ptr) + k) % NUM_REQ;
         c      = IDX_W'(c_full);
         if (!any && req[c]) begin
            any      = 1'b1;
            grant[c] = 1'b1;
            idx      = c;
         end
      end
   end
endmodule

// File: rtl/frame_buf_arb.sv
// Round-robin arbiter sharing one Avalon RAM port among frame-buffer clients,
// one command in flight at a time with read data routed back to its owner.
module frame_buf_arb
   import frame_buf_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned RD_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ram_rdy,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    ack,
   output logic [NUM_REQ-1:0]    rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   frame_buf_arb_if.master       avl,
   output logic                  busy,
   output logic                  err_timeout
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    owner_q, owner_d, ptr_q, ptr_d;
   logic                we_q, we_d, err_q, err_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, rd_data_q, rd_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d, rd_valid_q, rd_valid_d;

   logic [NUM_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;

   // The owner still holds req during its ack cycle; hide it from the picker.
   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req & ~ack_q),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         we_q       <= DEASSERT_H;
         err_q      <= DEASSERT_H;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         cnt_q      <= '0;
         ack_q      <= '0;
         rd_valid_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         we_q       <= we_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      we_d       = we_q;
      err_d      = err_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      cnt_d      = cnt_q;
      ack_d      = '0;
      rd_valid_d = '0;
      unique case (state_q)
         IDLE: begin
            if (ram_rdy && pick_any && |pick_grant) begin
               owner_d = pick_idx;
               we_d    = req_we[pick_idx];
               addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
               wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (avl.avl_ready) begin
               ack_d[owner_q] = ASSERT_H;
               ptr_d          = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
               cnt_d          = '0;
               state_d        = we_q ? IDLE : WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (avl.avl_rd_data_valid) begin
               rd_data_d           = avl.avl_rd_data;
               rd_valid_d[owner_q] = ASSERT_H;
               state_d             = IDLE;
            end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
               err_d   = ASSERT_H;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign avl.avl_write_req = (state_q == ISSUE) && we_q;
   assign avl.avl_read_req  = (state_q == ISSUE) && !we_q;
   assign avl.avl_addr      = addr_q;
   assign avl.avl_wdata     = wdata_q;

   assign ack         = ack_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign busy        = (state_q != IDLE);
   assign err_timeout = err_q;
endmodule

// File: tb/tb_frame_buf_arb.sv
// Scoreboard bench for frame_buf_arb: clients and a RAM model drive the DUT,
// expected commands/acks/read returns are queued and checked by a monitor.
module tb_frame_buf_arb;
   localparam int unsigned N  = 3;
   localparam int unsigned AW = 29;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 255;

   typedef struct packed {
      logic [1:0]    cl;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   typedef struct packed {
      logic [N-1:0]  vec;
      logic [DW-1:0] data;
   } rsp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              ram_rdy;
   logic [N-1:0]      req, req_we;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      ack, rd_valid;
   logic [DW-1:0]     rd_data;
   logic              busy, err_timeout;

   frame_buf_arb_if #(.ADDR_W(AW), .DATA_W(DW)) avl_bus ();

   frame_buf_arb #(
      .NUM_REQ    (N),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ram_rdy     (ram_rdy),
      .req         (req),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .ack         (ack),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .avl         (avl_bus),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   txn_t         pq[$];
   txn_t         exp_cmd[$];
   logic [N-1:0] exp_ack[$];
   rsp_t         exp_rd[$];

   int            ready_mode = 1;
   int            rd_delay   = 0;
   int            rd_cnt     = 0;
   logic [DW-1:0] rd_ret     = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic post(input logic [1:0] cl, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      txn_t t;
      t = '{cl: cl, we: we, addr: a, data: d};
      pq.push_back(t);
   endtask

   task automatic expect_cmd(input logic [1:0] cl, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
      txn_t         t;
      logic [N-1:0] v;
      t = '{cl: cl, we: we, addr: a, data: d};
      v = '0;
      v[cl] = 1'b1;
      exp_cmd.push_back(t);
      exp_ack.push_back(v);
   endtask

   task automatic expect_rd(input logic [1:0] cl, input logic [DW-1:0] d);
      rsp_t r;
      r.vec     = '0;
      r.vec[cl] = 1'b1;
      r.data    = d;
      exp_rd.push_back(r);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((exp_ack.size() != 0 || exp_rd.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   // Clients: hold req until ack, never re-raise within the ack cycle.
   initial begin : clients
      bit found;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < int'(N); i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
            end else if (!req[i]) begin
               found = 1'b0;
               for (int k = 0; k < pq.size(); k++) begin
                  if (!found && pq[k].cl == 2'(i)) begin
                     found = 1'b1;
                     req_we[i]               = pq[k].we;
                     req_addr[i*AW +: AW]    = pq[k].addr;
                     req_wdata[i*DW +: DW]   = pq[k].data;
                     req[i]                  = 1'b1;
                     pq.delete(k);
                  end
               end
            end
         end
      end
   end

   // RAM model: ready pattern plus delayed read return.
   initial begin : ram
      logic acc;
      avl_bus.avl_ready = 1'b0; avl_bus.avl_rd_data_valid = 1'b0; avl_bus.avl_rd_data = '0;
      forever begin
         @(negedge clk);
         acc = avl_bus.avl_ready && avl_bus.avl_read_req;
         @(posedge clk);
         #1;
         avl_bus.avl_rd_data_valid = 1'b0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               avl_bus.avl_rd_data_valid = 1'b1;
               avl_bus.avl_rd_data       = rd_ret;
            end
         end
         if (acc && rd_delay > 0) rd_cnt = rd_delay;
         case (ready_mode)
            0:       avl_bus.avl_ready = 1'b0;
            1:       avl_bus.avl_ready = 1'b1;
            default: avl_bus.avl_ready = ~avl_bus.avl_ready;
         endcase
      end
   end

   initial begin : monitor
      txn_t         e;
      logic [N-1:0] ea;
      rsp_t         er;
      forever begin
         @(negedge clk);
         if (busy) check("wr_rd_excl", 64'(avl_bus.avl_write_req & avl_bus.avl_read_req), 64'd0);
         if (avl_bus.avl_ready && (avl_bus.avl_write_req || avl_bus.avl_read_req)) begin
            if (exp_cmd.size() == 0) begin
               checks++; failures++;
               $display("FAIL cmd: unexpected command addr %0h", avl_bus.avl_addr);
            end else begin
               e = exp_cmd.pop_front();
               check("cmd", {avl_bus.avl_write_req, avl_bus.avl_addr,
                             avl_bus.avl_write_req ? avl_bus.avl_wdata : 32'h0},
                     {e.we, e.addr, e.we ? e.data : 32'h0});
            end
         end
         if (|ack) begin
            if (exp_ack.size() == 0) begin
               checks++; failures++;
               $display("FAIL ack: unexpected ack %b", ack);
            end else begin
               ea = exp_ack.pop_front();
               check("ack", 64'(ack), 64'(ea));
            end
         end
         if (|rd_valid) begin
            if (exp_rd.size() == 0) begin
               checks++; failures++;
               $display("FAIL rd_valid: unexpected rd_valid %b", rd_valid);
            end else begin
               er = exp_rd.pop_front();
               check("rd_valid", 64'(rd_valid), 64'(er.vec));
               check("rd_data", 64'(rd_data), 64'(er.data));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int c0, c1, c2, n;
      reset = 1'b0; ram_rdy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd", {avl_bus.avl_write_req, avl_bus.avl_read_req, busy}, 0);
      check("rst_ack", {ack, rd_valid, err_timeout}, 0);
      reset = 1'b1;

      // Held off by ram_rdy, then granted in pointer order.
      post(0, 1, 29'h100, 32'h1000);
      post(1, 1, 29'h101, 32'h1001);
      post(2, 1, 29'h102, 32'h1002);
      repeat (20) begin
         @(negedge clk);
         check("no_grant_not_rdy", {avl_bus.avl_write_req, avl_bus.avl_read_req, ack, busy}, 0);
      end
      expect_cmd(0, 1, 29'h100, 32'h1000);
      expect_cmd(1, 1, 29'h101, 32'h1001);
      expect_cmd(2, 1, 29'h102, 32'h1002);
      ram_rdy = 1'b1;
      wait_idle(40, "t1_done");

      // Continuous requests with a toggling ready.
      ready_mode = 2;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++)
            post(2'(i), 1, 29'(32'h200 + r*3 + i), 32'(32'hA0 + r*3 + i));
      expect_cmd(0, 1, 29'h200, 32'hA0);
      expect_cmd(1, 1, 29'h201, 32'hA1);
      expect_cmd(2, 1, 29'h202, 32'hA2);
      expect_cmd(0, 1, 29'h203, 32'hA3);
      expect_cmd(1, 1, 29'h204, 32'hA4);
      expect_cmd(2, 1, 29'h205, 32'hA5);
      wait_idle(100, "t3_done");

      // Client 0 write latency and same-client back-to-back period.
      ready_mode = 1;
      repeat (2) @(negedge clk);
      post(0, 1, 29'h10, 32'h00FF_FFFF);
      post(0, 1, 29'h11, 32'h0000_0011);
      expect_cmd(0, 1, 29'h10, 32'h00FF_FFFF);
      expect_cmd(0, 1, 29'h11, 32'h0000_0011);
      for (n = 0; n < 10 && !req[0]; n++) @(negedge clk);
      c0 = cyc;
      for (n = 0; n < 10 && !avl_bus.avl_write_req; n++) @(negedge clk);
      c1 = cyc;
      check("wr_latency", 64'(c1 - c0), 64'd1);
      for (n = 0; n < 10 && avl_bus.avl_write_req; n++) @(negedge clk);
      for (n = 0; n < 10 && !avl_bus.avl_write_req; n++) @(negedge clk);
      c2 = cyc;
      check("b2b_period", 64'(c2 - c1), 64'd3);
      wait_idle(20, "t2_done");

      // Read with data returned later.
      rd_delay = 7; rd_ret = 32'h00FF_FFFF;
      post(2, 0, 29'h2, 32'h0);
      expect_cmd(2, 0, 29'h2, 32'h0);
      expect_rd(2, 32'h00FF_FFFF);
      wait_idle(40, "t4_done");
      check("rd_data_hold", 64'(rd_data), 64'h00FF_FFFF);

      // Read that never returns in time; late data must be ignored.
      rd_delay = 300; rd_ret = 32'hDEAD_BEEF;
      post(1, 0, 29'h5, 32'h0);
      expect_cmd(1, 0, 29'h5, 32'h0);
      for (n = 0; n < 20 && !ack[1]; n++) @(negedge clk);
      c0 = cyc;
      for (n = 0; n < 300 && !err_timeout; n++) @(negedge clk);
      c1 = cyc;
      check("timeout_cycles", 64'(c1 - c0), 64'(TO));
      check("idle_after_timeout", 64'(busy), 64'd0);
      post(0, 1, 29'h20, 32'hA5A5_0001);
      expect_cmd(0, 1, 29'h20, 32'hA5A5_0001);
      wait_idle(20, "t5_write_done");
      repeat (60) @(negedge clk);
      check("err_sticky", 64'(err_timeout), 64'd1);

      // Reset while stuck in ISSUE.
      ready_mode = 0; rd_delay = 0;
      post(2, 1, 29'h30, 32'h30);
      for (n = 0; n < 20 && !avl_bus.avl_write_req; n++) @(negedge clk);
      check("stuck_issue", 64'(avl_bus.avl_write_req), 64'd1);
      #2;
      reset = 1'b0;
      req = '0;
      pq.delete();
      #1;
      check("rst_mid_cmd", {avl_bus.avl_write_req, avl_bus.avl_read_req, busy}, 0);
      check("rst_mid_ack", {ack, rd_valid, err_timeout}, 0);
      check("rst_mid_rd_data", 64'(rd_data), 64'd0);
      check("rst_mid_addr", {avl_bus.avl_addr, avl_bus.avl_wdata}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ready_mode = 1;
      post(0, 1, 29'h40, 32'h40);
      post(2, 1, 29'h42, 32'h42);
      expect_cmd(0, 1, 29'h40, 32'h40);
      expect_cmd(2, 1, 29'h42, 32'h42);
      wait_idle(40, "t6_done");

      check("sb_drained", 64'(exp_cmd.size() + exp_ack.size() + exp_rd.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
